rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/rr_arbiter_8_if.sv | 21 ++
 rtl/rr_arbiter_8.sv | 98 +++++++++
 tb/tb_rr_arbiter_8.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle shared between the requesters and rr_arbiter_8.
// The master side is the requester population; the slave side is the arbiter.
interface rr_arbiter_8_if;
    logic       enable;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    modport master (
        output enable, req, done,
        input  grant, grant_idx, grant_valid, timeout
    );

    modport slave (
        input  enable, req, done,
        output grant, grant_idx, grant_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded hold time and a registered one-hot grant.
// Every release is followed by one dead cycle in IDLE before the next grant.
module rr_arbiter_8 #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_8_if.slave arb
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    logic [0:0] r_state;
    logic [2:0] r_ptr;
    logic [3:0] r_hold_cnt;
    logic [7:0] r_grant;
    logic [2:0] r_grant_idx;
    logic       r_grant_valid;
    logic       r_timeout;

    logic [7:0] w_req_rot;
    logic [2:0] w_offset;
    logic       w_found;
    logic [2:0] w_sel_idx;
    logic       w_owner_req;
    logic       w_hold_hit;
    logic       w_release;
    logic       w_timeout;

    // Rotate so bit 0 is the requester at ptr; the lowest set bit is then the winner.
    always_comb begin
        w_req_rot = 8'({arb.req, arb.req} >> r_ptr);
        w_found   = 1'b0;
        w_offset  = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (!w_found && w_req_rot[k]) begin
                w_found  = 1'b1;
                w_offset = 3'(k);
            end
        end
        w_sel_idx = r_ptr + w_offset;
    end

    always_comb begin
        w_owner_req = arb.req[r_grant_idx];
        w_hold_hit  = (r_hold_cnt == HOLD_LIM);
        w_release   = arb.done || !w_owner_req || !arb.enable || w_hold_hit;
        w_timeout   = w_hold_hit && !arb.done && w_owner_req && arb.enable;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_hold_cnt    <= '0;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timeout <= 1'b0;
                    if (arb.enable && w_found) begin
                        r_state       <= ST_GRANT;
                        r_grant       <= 8'd1 << w_sel_idx;
                        r_grant_idx   <= w_sel_idx;
                        r_grant_valid <= 1'b1;
                        r_ptr         <= w_sel_idx + 3'd1;
                        r_hold_cnt    <= 4'd1;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state       <= ST_IDLE;
                        r_grant       <= '0;
                        r_grant_idx   <= '0;
                        r_grant_valid <= 1'b0;
                        r_hold_cnt    <= '0;
                        r_timeout     <= w_timeout;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 4'd1;
                        r_timeout  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign arb.grant       = r_grant;
    assign arb.grant_idx   = r_grant_idx;
    assign arb.grant_valid = r_grant_valid;
    assign arb.timeout     = r_timeout;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed scenarios plus random traffic against an
// integer-level reference model (owner index, pointer, held-cycle count).
module tb_rr_arbiter_8;
    localparam int HOLD = 15;

    logic clk;
    logic rst;
    rr_arbiter_8_if arb();

    rr_arbiter_8 #(.HOLD_MAX(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: -1 means nobody owns the resource.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_to    = 1'b0;

    task automatic model_update();
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            if (arb.enable && arb.req != 8'd0) begin
                for (int k = 0; k < 8; k++) begin
                    int idx;
                    idx = (m_ptr + k) % 8;
                    if (m_owner < 0 && arb.req[idx]) begin
                        m_owner = idx;
                        m_ptr   = (idx + 1) % 8;
                        m_cnt   = 1;
                    end
                end
            end
        end else begin
            bit by_done, by_req, by_en, by_hold;
            by_done = arb.done;
            by_req  = !arb.req[m_owner];
            by_en   = !arb.enable;
            by_hold = (m_cnt == HOLD);
            if (by_done || by_req || by_en || by_hold) begin
                m_to    = by_hold && !by_done && !by_req && !by_en;
                m_owner = -1;
                m_cnt   = 0;
            end else begin
                m_cnt = m_cnt + 1;
                m_to  = 1'b0;
            end
        end
    endtask

    // Advance one clock; model sees the same inputs the DUT samples, outputs settle #1 later.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; arb.enable = 1'b0; arb.req = 8'd0; arb.done = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; arb.enable = 1'b1; arb.req = 8'hFF; arb.done = 1'b1;
        step();
        step();
        n_cmp++; if (arb.grant !== 8'd0) begin n_err++; $display("FAIL reset_grant: got %h want 00", arb.grant); end
        n_cmp++; if (arb.grant_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", arb.grant_idx); end
        n_cmp++; if (arb.grant_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", arb.grant_valid); end
        n_cmp++; if (arb.timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", arb.timeout); end
        rst = 1'b0; arb.done = 1'b0; arb.req = 8'd0;
    endtask

    task automatic test_single_grant();
        do_reset();
        arb.enable = 1'b1; arb.req = 8'b0000_0100;
        step();
        n_cmp++; if (arb.grant !== 8'b0000_0100) begin n_err++; $display("FAIL single_grant: got %b want 00000100", arb.grant); end
        n_cmp++; if (arb.grant_idx !== 3'd2) begin n_err++; $display("FAIL single_idx: got %0d want 2", arb.grant_idx); end
        n_cmp++; if (arb.grant_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", arb.grant_valid); end
        arb.done = 1'b1;
        step();
        arb.done = 1'b0;
        n_cmp++; if (arb.grant !== 8'd0 || arb.grant_valid !== 1'b0) begin n_err++; $display("FAIL single_release: got %b/%b want 0/0", arb.grant, arb.grant_valid); end
        n_cmp++; if (arb.timeout !== 1'b0) begin n_err++; $display("FAIL single_no_timeout: got %b want 0", arb.timeout); end
    endtask

    task automatic test_done_in_idle();
        do_reset();
        arb.enable = 1'b1; arb.req = 8'b0000_0100; arb.done = 1'b1;
        step();
        arb.done = 1'b0;
        n_cmp++; if (arb.grant_valid !== 1'b1 || arb.grant_idx !== 3'd2) begin n_err++; $display("FAIL idle_done_ignored: got valid %b idx %0d want 1/2", arb.grant_valid, arb.grant_idx); end
    endtask

    task automatic test_rotation();
        do_reset();
        arb.enable = 1'b1; arb.req = 8'hFF;
        step();
        for (int i = 0; i < 9; i++) begin
            n_cmp++; if (arb.grant_valid !== 1'b1 || arb.grant_idx !== 3'(i % 8) || arb.grant !== (8'd1 << (i % 8))) begin
                n_err++; $display("FAIL rotate_%0d: got idx %0d grant %b valid %b want idx %0d", i, arb.grant_idx, arb.grant, arb.grant_valid, i % 8);
            end
            arb.done = 1'b1;
            step();
            arb.done = 1'b0;
            n_cmp++; if (arb.grant_valid !== 1'b0 || arb.grant !== 8'd0) begin n_err++; $display("FAIL rotate_dead_%0d: got valid %b grant %b want 0/0", i, arb.grant_valid, arb.grant); end
            step();
        end
    endtask

    task automatic test_timeout();
        int held;
        do_reset();
        arb.enable = 1'b1; arb.req = 8'b1000_0000;
        step();
        held = arb.grant_valid ? 1 : 0;
        for (int i = 0; i < 40 && arb.grant_valid; i++) begin
            step();
            if (arb.grant_valid) held++;
        end
        n_cmp++; if (held !== HOLD) begin n_err++; $display("FAIL timeout_hold_len: got %0d want %0d", held, HOLD); end
        n_cmp++; if (arb.timeout !== 1'b1 || arb.grant !== 8'd0) begin n_err++; $display("FAIL timeout_pulse: got timeout %b grant %b want 1/0", arb.timeout, arb.grant); end
        arb.req = 8'hFF;
        step();
        n_cmp++; if (arb.timeout !== 1'b0) begin n_err++; $display("FAIL timeout_one_cycle: got %b want 0", arb.timeout); end
        n_cmp++; if (arb.grant_valid !== 1'b1 || arb.grant_idx !== 3'd0) begin n_err++; $display("FAIL timeout_ptr_wrap: got idx %0d valid %b want 0/1", arb.grant_idx, arb.grant_valid); end
    endtask

    task automatic test_enable_drop();
        int seen;
        do_reset();
        arb.enable = 1'b1; arb.req = 8'b0000_1000;
        step();
        n_cmp++; if (arb.grant_idx !== 3'd3) begin n_err++; $display("FAIL en_setup: got idx %0d want 3", arb.grant_idx); end
        arb.enable = 1'b0; arb.req = 8'hFF;
        step();
        n_cmp++; if (arb.grant !== 8'd0) begin n_err++; $display("FAIL en_revoke: got %b want 0", arb.grant); end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (arb.grant_valid !== 1'b0) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL en_block: got %0d grant cycles want 0", seen); end
        arb.enable = 1'b1;
        step();
        n_cmp++; if (arb.grant_valid !== 1'b1 || arb.grant_idx !== 3'd4) begin n_err++; $display("FAIL en_resume: got idx %0d valid %b want 4/1", arb.grant_idx, arb.grant_valid); end
    endtask

    task automatic test_req_drop();
        do_reset();
        arb.enable = 1'b1; arb.req = 8'b0010_0000;
        step();
        n_cmp++; if (arb.grant_idx !== 3'd5) begin n_err++; $display("FAIL drop_setup: got idx %0d want 5", arb.grant_idx); end
        arb.req = 8'b0000_0011;
        step();
        n_cmp++; if (arb.grant !== 8'd0 || arb.timeout !== 1'b0) begin n_err++; $display("FAIL drop_release: got grant %b timeout %b want 0/0", arb.grant, arb.timeout); end
        step();
        n_cmp++; if (arb.grant_valid !== 1'b1 || arb.grant_idx !== 3'd0) begin n_err++; $display("FAIL drop_wrap: got idx %0d valid %b want 0/1", arb.grant_idx, arb.grant_valid); end
    endtask

    task automatic test_rst_mid_grant();
        do_reset();
        arb.enable = 1'b1; arb.req = 8'b0100_0000;
        step();
        n_cmp++; if (arb.grant_idx !== 3'd6) begin n_err++; $display("FAIL rstmid_setup: got idx %0d want 6", arb.grant_idx); end
        rst = 1'b1;
        step();
        n_cmp++; if ({arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout} !== 13'd0) begin
            n_err++; $display("FAIL rstmid_clear: got grant %b idx %0d valid %b timeout %b want all 0", arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout);
        end
        rst = 1'b0; arb.req = 8'b0100_0001;
        step();
        n_cmp++; if (arb.grant_valid !== 1'b1 || arb.grant_idx !== 3'd0) begin n_err++; $display("FAIL rstmid_first: got idx %0d valid %b want 0/1", arb.grant_idx, arb.grant_valid); end
    endtask

    task automatic test_random();
        int bad = 0;
        int tos = 0;
        logic [7:0] e_grant;
        logic [2:0] e_idx;
        do_reset();
        arb.enable = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            arb.enable = ($urandom_range(0, 39) != 0);
            arb.done   = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 23) == 0) begin
                if ($urandom_range(0, 1) == 0) arb.req = 8'($urandom);
                else arb.req = 8'd1 << $urandom_range(0, 7);
            end
            step();
            e_grant = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
            e_idx   = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
            if (m_to) tos++;
            n_cmp++;
            if (arb.grant !== e_grant || arb.grant_idx !== e_idx ||
                arb.grant_valid !== (m_owner >= 0) || arb.timeout !== m_to) begin
                n_err++;
                if (bad < 10) $display("FAIL random_c%0d: got grant %b idx %0d valid %b to %b want %b %0d %b %b",
                    c, arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout, e_grant, e_idx, (m_owner >= 0), m_to);
                bad++;
            end
        end
        rst = 1'b0; arb.done = 1'b0;
        $display("random phase: %0d model timeouts observed", tos);
    endtask

    initial begin
        rst = 1'b1; arb.enable = 1'b0; arb.req = 8'd0; arb.done = 1'b0;
        test_reset();
        test_single_grant();
        test_done_in_idle();
        test_rotation();
        test_timeout();
        test_enable_drop();
        test_req_drop();
        test_rst_mid_grant();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
